im_loader: RTL and testbench

//   Byte-stream boot loader: the write-side counterpart of the instruction ROM (IM).
//   It receives a length-prefixed program image over a valid/ready byte interface and

---
 rtl/im_loader.sv | 162 ++++++++++++++++
 tb/tb_im_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: byte-stream boot loader feeding the instruction memory.
// Receives a length-prefixed image (count[15:8], count[7:0], then count big-endian words)
// over a valid/ready byte interface. Each assembled word is written to consecutive word
// addresses starting at BASE_ADDR. The CPU is held in reset until the image is complete.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset
//   rx_valid  byte on rx_data is valid
//   rx_data   stream byte
//   rx_ready  loader accepts a byte this cycle
//   reload    one-cycle pulse, restarts loading from DONE or ERR
//   im_we     instruction memory write strobe (one cycle per word)
//   im_addr   byte address of the write
//   im_wdata  word to write
//   busy      header/data reception in progress
//   done      image fully written
//   err       header count exceeded DEPTH
//   cpu_hold  1 = keep the CPU in reset
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [2:0] StHdr0  = 3'd0;
  localparam logic [2:0] StHdr1  = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  // Only the first three bytes need buffering; the fourth goes straight to im_wdata.
  logic [23:0] wbuf_q, wbuf_d;

  logic        im_we_d, busy_d, done_d, err_d, cpu_hold_d;
  logic [31:0] im_addr_d, im_wdata_d;
  logic        xfer;
  logic [15:0] hdr_count;

  assign rx_ready  = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
  assign xfer      = rx_valid && rx_ready;
  assign hdr_count = {count_q[15:8], rx_data};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    wbuf_d     = wbuf_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr;
    im_wdata_d = im_wdata;

    case (state_q)
      StHdr0: begin
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          count_d    = hdr_count;
          byte_idx_d = 2'd0;
          word_idx_d = 16'd0;
          if (hdr_count == 16'd0) begin
            state_d = StDone;
          end else if (32'(hdr_count) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          wbuf_d     = {wbuf_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Register the write now so im_we is high exactly during WRITE.
            state_d    = StWrite;
            im_we_d    = 1'b1;
            im_wdata_d = {wbuf_q, rx_data};
            im_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        if (32'(word_idx_q) == 32'(count_q) - 32'd1) begin
          state_d = StDone;
        end else begin
          state_d = StData;
        end
      end
      StDone, StErr: begin
        if (reload) begin
          state_d    = StHdr0;
          count_d    = 16'd0;
          byte_idx_d = 2'd0;
          word_idx_d = 16'd0;
        end
      end
      default: state_d = StHdr0;
    endcase

    busy_d     = (state_d == StHdr0) || (state_d == StHdr1) ||
                 (state_d == StData) || (state_d == StWrite);
    done_d     = (state_d == StDone);
    err_d      = (state_d == StErr);
    cpu_hold_d = (state_d != StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StHdr0;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= 16'd0;
      wbuf_q     <= 24'd0;
      im_we      <= 1'b0;
      im_addr    <= BASE_ADDR;
      im_wdata   <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      wbuf_q     <= wbuf_d;
      im_we      <= im_we_d;
      im_addr    <= im_addr_d;
      im_wdata   <= im_wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a stream-level model pushes expected writes into a queue,
// a negedge monitor pops and compares on every im_we pulse.
module tb_im_loader;

  localparam logic [31:0] Base  = 32'h0000_3000;
  localparam int unsigned Depth = 4096;

  logic        clk = 1'b0;
  logic        reset, rx_valid, rx_ready, reload;
  logic [7:0]  rx_data;
  logic        im_we, busy, done, err, cpu_hold;
  logic [31:0] im_addr, im_wdata;

  im_loader #(.BASE_ADDR(Base), .DEPTH(Depth)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .reload   (reload),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_we_cyc = -1;
  int  last_acc_cyc = -1;
  int  n_exp_writes;
  bit  exp_done, exp_err;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", im_addr, e.a);
        chk("wr_data", im_wdata, e.d);
      end
      last_we_cyc = cyc;
    end
    if (reset === 1'b1 && (done === 1'b1 || err === 1'b1))
      chk("done_err_excl", {31'd0, done & err}, 32'd0);
  end

  // Reference model: decode the whole stream from the format rules.
  task automatic model(input byte unsigned s[$]);
    int unsigned cnt;
    cnt = {s[0], s[1]};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n_exp_writes = 0;
    if (cnt == 0) begin
      exp_done = 1'b1;
    end else if (cnt > Depth) begin
      exp_err = 1'b1;
    end else begin
      exp_done = 1'b1;
      n_exp_writes = int'(cnt);
      for (int i = 0; i < int'(cnt); i++) begin
        wr_t w;
        w.a = Base + 32'(4 * i);
        w.d = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
        sb.push_back(w);
      end
    end
  endtask

  task automatic send_byte(input byte unsigned b, input int gap);
    int n;
    @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic run_image(input byte unsigned s[$], input int max_gap, input int nsend);
    int n;
    model(s);
    for (int i = 0; i < nsend; i++) send_byte(s[i], int'($urandom_range(max_gap, 0)));
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("final_done", {31'd0, done}, {31'd0, exp_done});
    chk("final_err", {31'd0, err}, {31'd0, exp_err});
    chk("final_cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (exp_done && n_exp_writes > 0) chk("done_latency", 32'(cyc), 32'(last_we_cyc + 1));
    if (exp_done && n_exp_writes == 0) chk("done_latency_hdr", 32'(cyc), 32'(last_acc_cyc));
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_err", {31'd0, err}, 32'd0);
    chk("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reload_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_im_addr", im_addr, Base);
    chk("rst_im_wdata", im_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    byte unsigned t1[$];
    byte unsigned s[$];
    int unsigned cnt;

    reset = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    reload = 1'b0;
    t1 = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h08, 8'h12, 8'h34};

    repeat (2) @(posedge clk);
    do_reset();

    // T1: back-to-back stream.
    run_image(t1, 0, t1.size());
    do_reload();

    // T2: empty image.
    s = '{8'h00, 8'h00};
    run_image(s, 0, 2);
    do_reload();

    // T3: count 4097 -> error, no further bytes accepted.
    s = '{8'h10, 8'h01};
    run_image(s, 0, 2);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("err_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("err_sticky", {31'd0, err}, 32'd1);
    end
    rx_valid = 1'b0;
    do_reload();

    // T4: count == DEPTH, incrementing words.
    s.delete();
    s.push_back(8'h10);
    s.push_back(8'h00);
    for (int i = 0; i < int'(Depth); i++) begin
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(i);
      s.push_back(w[31:24]);
      s.push_back(w[23:16]);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
    end
    run_image(s, 0, s.size());
    chk("t4_last_addr", im_addr, 32'h0000_6FFC);
    do_reload();

    // T5: T1 with random gaps.
    run_image(t1, 3, t1.size());
    do_reload();

    // Random small images with gaps.
    for (int k = 0; k < 4; k++) begin
      cnt = $urandom_range(6, 1);
      s.delete();
      s.push_back(8'h00);
      s.push_back(8'(cnt));
      for (int i = 0; i < int'(4 * cnt); i++) s.push_back(8'($urandom));
      run_image(s, 3, s.size());
      do_reload();
    end

    // T6: reset mid-image; the 6th byte is presented on the reset edge and discarded.
    for (int i = 0; i < 5; i++) send_byte(t1[i], 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = t1[5];
    reset    = 1'b0;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("t6_rst_im_we", {31'd0, im_we}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_image(t1, 0, t1.size());
    do_reload();
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_image(s, 0, s.size());

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
